// File: rtl/sdram_port_arbiter.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | sdram_port_arbiter: round-robin sharing of one SDRAM word port by two     |
// | requesters, one transaction at a time, with a completion watchdog.        |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module sdram_port_arbiter #(
  parameter int          TIMEOUT_CYCLES = 1023,
  parameter logic [31:0] TIMEOUT_RDATA  = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [23:0] p0_addr,
  input  logic [31:0] p0_wdata,
  output logic        p0_ack,
  output logic [31:0] p0_rdata,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [23:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p1_ack,
  output logic [31:0] p1_rdata,
  output logic        sdram_rd,
  output logic        sdram_wr,
  output logic [23:0] sdram_addr,
  output logic [31:0] sdram_wdata,
  input  logic [31:0] sdram_rdata,
  input  logic        sdram_busy,
  input  logic        sdram_rdata_valid,
  output logic        owner,
  output logic        active,
  output logic        err_timeout
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WAIT_RD = 2'd1;
  localparam logic [1:0] S_WAIT_WR = 2'd2;
  localparam logic [9:0] C_TIMEOUT = 10'(TIMEOUT_CYCLES);

  logic [1:0]  r_state;
  logic [9:0]  r_timer;
  logic        r_started;
  logic        r_last;
  logic        r_owner;
  logic        r_active;
  logic        r_err;
  logic        r_rd;
  logic        r_wr;
  logic [23:0] r_addr;
  logic [31:0] r_wdata;
  logic [1:0]  r_ack;
  logic [31:0] r_rdata0;
  logic [31:0] r_rdata1;

  logic        w_q0;
  logic        w_q1;
  logic        w_grant;
  logic        w_gnt_port;
  logic        w_gnt_we;
  logic [23:0] w_gnt_addr;
  logic [31:0] w_gnt_wdata;
  logic [9:0]  w_timer_inc;
  logic        w_timeout;
  logic        w_done;
  logic        w_done_err;
  logic [31:0] w_done_data;

  // A port whose ack is high this cycle is masked so it cannot be re-granted
  // while its requester is still dropping req.
  always_comb begin
    w_q0        = p0_req & ~r_ack[0];
    w_q1        = p1_req & ~r_ack[1];
    w_grant     = (r_state == S_IDLE) & ~sdram_busy & (w_q0 | w_q1);
    w_gnt_port  = (w_q0 & w_q1) ? ~r_last : w_q1;
    w_gnt_we    = w_gnt_port ? p1_we    : p0_we;
    w_gnt_addr  = w_gnt_port ? p1_addr  : p0_addr;
    w_gnt_wdata = w_gnt_port ? p1_wdata : p0_wdata;
    w_timer_inc = r_timer + 10'd1;
    w_timeout   = (w_timer_inc == C_TIMEOUT);
  end

  // A real completion event takes priority over a coincident timeout.
  always_comb begin
    w_done      = 1'b0;
    w_done_err  = 1'b0;
    w_done_data = 32'h0;
    case (r_state)
      S_WAIT_RD: begin
        if (sdram_rdata_valid) begin
          w_done      = 1'b1;
          w_done_data = sdram_rdata;
        end else if (w_timeout) begin
          w_done      = 1'b1;
          w_done_err  = 1'b1;
          w_done_data = TIMEOUT_RDATA;
        end
      end
      S_WAIT_WR: begin
        if (r_started & ~sdram_busy) begin
          w_done = 1'b1;
        end else if (w_timeout) begin
          w_done     = 1'b1;
          w_done_err = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_timer   <= 10'd0;
      r_started <= 1'b0;
      r_last    <= 1'b1;
      r_owner   <= 1'b0;
      r_active  <= 1'b0;
      r_err     <= 1'b0;
      r_rd      <= 1'b0;
      r_wr      <= 1'b0;
      r_addr    <= 24'h0;
      r_wdata   <= 32'h0;
      r_ack     <= 2'b00;
      r_rdata0  <= 32'h0;
      r_rdata1  <= 32'h0;
    end else begin
      r_rd     <= 1'b0;
      r_wr     <= 1'b0;
      r_ack    <= 2'b00;
      r_rdata0 <= 32'h0;
      r_rdata1 <= 32'h0;
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_addr    <= w_gnt_addr;
            r_wdata   <= w_gnt_wdata;
            r_rd      <= ~w_gnt_we;
            r_wr      <= w_gnt_we;
            r_owner   <= w_gnt_port;
            r_last    <= w_gnt_port;
            r_active  <= 1'b1;
            r_timer   <= 10'd0;
            r_started <= 1'b0;
            r_state   <= w_gnt_we ? S_WAIT_WR : S_WAIT_RD;
          end
        end
        S_WAIT_RD, S_WAIT_WR: begin
          r_timer <= w_timer_inc;
          if ((r_state == S_WAIT_WR) && sdram_busy) begin
            r_started <= 1'b1;
          end
          if (w_done) begin
            r_state  <= S_IDLE;
            r_active <= 1'b0;
            if (w_done_err) begin
              r_err <= 1'b1;
            end
            if (r_owner) begin
              r_ack[1] <= 1'b1;
              r_rdata1 <= w_done_data;
            end else begin
              r_ack[0] <= 1'b1;
              r_rdata0 <= w_done_data;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign p0_ack      = r_ack[0];
  assign p1_ack      = r_ack[1];
  assign p0_rdata    = r_rdata0;
  assign p1_rdata    = r_rdata1;
  assign sdram_rd    = r_rd;
  assign sdram_wr    = r_wr;
  assign sdram_addr  = r_addr;
  assign sdram_wdata = r_wdata;
  assign owner       = r_owner;
  assign active      = r_active;
  assign err_timeout = r_err;

endmodule
`default_nettype wire

// File: tb/tb_sdram_port_arbiter.sv
`default_nettype none
// Bench for sdram_port_arbiter: vector table, hand sequences and a randomized
// run scored against a transaction-level model of the arbitration rules.
module tb_sdram_port_arbiter;

  localparam int T = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [23:0] p0_addr, p1_addr;
  logic [31:0] p0_wdata, p1_wdata;
  logic        p0_ack, p1_ack;
  logic [31:0] p0_rdata, p1_rdata;
  logic        sdram_rd, sdram_wr;
  logic [23:0] sdram_addr;
  logic [31:0] sdram_wdata, sdram_rdata;
  logic        sdram_busy, sdram_rdata_valid;
  logic        owner, active, err_timeout;

  int total = 0;
  int bad   = 0;

  sdram_port_arbiter #(.TIMEOUT_CYCLES(T), .TIMEOUT_RDATA(32'hDEADBEEF)) dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_rdata(p1_rdata),
    .sdram_rd(sdram_rd), .sdram_wr(sdram_wr), .sdram_addr(sdram_addr),
    .sdram_wdata(sdram_wdata), .sdram_rdata(sdram_rdata), .sdram_busy(sdram_busy),
    .sdram_rdata_valid(sdram_rdata_valid),
    .owner(owner), .active(active), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    bit          port;
    bit          we;
    logic [23:0] addr;
    logic [31:0] wdata;
    int          dly;       // read: valid offset from cmd (-1 never); write: busy length
    logic [31:0] rdata;
    int          exp_lat;   // cycles from command pulse to ack
    logic [31:0] exp_data;
    bit          exp_err;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0;
    p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0;
    sdram_busy = 0; sdram_rdata_valid = 0; sdram_rdata = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    clear_inputs();
    repeat (2) @(negedge clk);
    reset = 0;
  endtask

  task automatic no_activity(input string nm, input int n);
    bit seen = 0;
    repeat (n) begin
      @(negedge clk);
      if (sdram_rd | sdram_wr | p0_ack | p1_ack) seen = 1;
    end
    chk(nm, seen, 0);
  endtask

  task automatic run_vec(input vec_t v);
    bit seen = 0;
    bit done = 0;
    int lat  = -1;
    int j    = 0;
    if (v.port) begin
      p1_we = v.we; p1_addr = v.addr; p1_wdata = v.wdata; p1_req = 1;
    end else begin
      p0_we = v.we; p0_addr = v.addr; p0_wdata = v.wdata; p0_req = 1;
    end
    for (int k = 0; k < 6 && !seen; k++) begin
      @(negedge clk);
      if (sdram_rd | sdram_wr) seen = 1;
    end
    chk("cmd_seen", seen, 1);
    chk("cmd_kind", {sdram_rd, sdram_wr}, v.we ? 2'b01 : 2'b10);
    chk("cmd_addr", sdram_addr, v.addr);
    if (v.we) chk("cmd_wdata", sdram_wdata, v.wdata);
    chk("cmd_owner_active", {owner, active}, {v.port, 1'b1});
    while (!done && j < 40) begin
      if (j > 0) begin
        if (j == 1) chk("cmd_one_cycle", {sdram_rd, sdram_wr}, 2'b00);
        if (p0_ack | p1_ack) begin
          done = 1;
          lat  = j;
        end
      end
      if (!done) begin
        if (v.we) begin
          sdram_busy = (j >= 1 && j <= v.dly);
        end else begin
          sdram_rdata_valid = (j == v.dly);
          sdram_rdata = (j == v.dly) ? v.rdata : 32'h0;
        end
        @(negedge clk);
        j++;
      end
    end
    chk("ack_latency", lat, v.exp_lat);
    chk("ack_port", {p1_ack, p0_ack}, v.port ? 2'b10 : 2'b01);
    chk("ack_rdata", v.port ? p1_rdata : p0_rdata, v.exp_data);
    chk("other_rdata", v.port ? p0_rdata : p1_rdata, 0);
    chk("active_clear", active, 0);
    chk("err_timeout", err_timeout, v.exp_err);
    sdram_busy = 0; sdram_rdata_valid = 0; sdram_rdata = 0;
    @(negedge clk);
    p0_req = 0; p1_req = 0;
    no_activity("no_dup", 4);
  endtask

  // Both ports hold read requests; grants must alternate starting with port 0.
  task automatic run_contention(input int n);
    int  grants = 0, acks = 0, cyc = 0, cmd_cyc = -100, k;
    bit  prev_busy = 0, eo;
    p0_we = 0; p0_addr = 24'h000100; p0_req = 1;
    p1_we = 0; p1_addr = 24'h000200; p1_req = 1;
    while (acks < n && cyc < 200) begin
      if (sdram_rd | sdram_wr) begin
        eo = (grants % 2) == 1;
        chk("rr_order", {sdram_wr, owner}, {1'b0, eo});
        chk("rr_addr", sdram_addr, eo ? 24'h000200 : 24'h000100);
        chk("rr_rd_not_busy", prev_busy, 0);
        cmd_cyc = cyc;
        grants++;
      end
      if (p0_ack | p1_ack) begin
        chk("rr_ack_port", {p1_ack, p0_ack}, (acks % 2) == 1 ? 2'b10 : 2'b01);
        chk("rr_rdata", p0_ack ? p0_rdata : p1_rdata, 32'hC0DE0000 + acks);
        chk("rr_latency", cyc - cmd_cyc, 4);
        acks++;
        if (acks == n) begin
          p0_req = 0; p1_req = 0;
        end
      end
      k = cyc - cmd_cyc;
      sdram_busy = (k == 1 || k == 2 || k == 4);
      sdram_rdata_valid = (k == 3);
      sdram_rdata = (k == 3) ? 32'hC0DE0000 + acks : 32'h0;
      prev_busy = sdram_busy;
      cyc++;
      @(negedge clk);
    end
    chk("rr_acks", acks, n);
    chk("rr_grants", grants, n);
    clear_inputs();
    no_activity("rr_drain", 4);
  endtask

  task automatic run_random(input int ncyc);
    bit          rq[2], rwe[2], ackprev[2], q[2];
    logic [23:0] raddr[2];
    logic [31:0] rwd[2], ed[2];
    bit          m_out = 0, m_port = 0, m_we = 0, m_to = 0;
    bit          m_last = 1, m_owner = 0, m_err = 0;
    int          m_cmd = 0, m_ack = 0, m_dly = 0, m_s = 0, m_len = 0, lat, k;
    logic [31:0] m_data = 0, m_rd = 0;
    bit          e_cmd = 0, e_port = 0, e_we = 0, e_act;
    logic [23:0] e_addr = 0;
    logic [31:0] e_wdata = 0;
    bit [1:0]    ackp;
    for (int p = 0; p < 2; p++) begin
      rq[p] = 0; rwe[p] = 0; ackprev[p] = 0; raddr[p] = 0; rwd[p] = 0;
    end
    for (int d = 0; d < ncyc; d++) begin
      if (e_cmd) begin
        m_out = 1; m_cmd = d; m_port = e_port; m_we = e_we;
        m_owner = e_port; m_last = e_port;
        if (!e_we) begin
          m_dly = ($urandom % 10 == 0) ? 99 : int'($urandom_range(0, 16));
          m_rd  = $urandom;
          m_to  = (m_dly + 1 > T);
          lat   = m_to ? T : m_dly + 1;
          m_data = m_to ? 32'hDEADBEEF : m_rd;
        end else begin
          m_s   = $urandom_range(1, 3);
          m_len = ($urandom % 10 == 0) ? 0 : int'($urandom_range(1, 12));
          m_to  = !(m_len > 0 && m_s + m_len + 1 <= T);
          lat   = m_to ? T : m_s + m_len + 1;
          m_data = 32'h0;
        end
        m_ack = d + lat;
      end
      ackp = 2'b00; ed[0] = 0; ed[1] = 0;
      if (m_out && d == m_ack) begin
        ackp[m_port] = 1'b1;
        ed[m_port] = m_data;
        if (m_to) m_err = 1;
      end
      e_act = m_out && d < m_ack;
      chk("rnd_ctrl", {sdram_rd, sdram_wr, p0_ack, p1_ack, active, owner, err_timeout},
          {e_cmd && !e_we, e_cmd && e_we, ackp[0], ackp[1], e_act, m_owner, m_err});
      chk("rnd_rdata", {p0_rdata, p1_rdata}, {ed[0], ed[1]});
      if (e_cmd) begin
        chk("rnd_addr", sdram_addr, e_addr);
        if (e_we) chk("rnd_wdata", sdram_wdata, e_wdata);
      end
      if (ackp != 2'b00) m_out = 0;
      for (int p = 0; p < 2; p++) begin
        if (rq[p] && ackprev[p]) begin
          if (($urandom % 2 == 0) || d > ncyc - 30) rq[p] = 0;
          else begin
            rwe[p] = $urandom % 2; raddr[p] = 24'($urandom); rwd[p] = $urandom;
          end
        end else if (!rq[p] && d < ncyc - 30 && ($urandom % 3 == 0)) begin
          rq[p] = 1; rwe[p] = $urandom % 2; raddr[p] = 24'($urandom); rwd[p] = $urandom;
        end
        ackprev[p] = ackp[p];
      end
      p0_req = rq[0]; p0_we = rwe[0]; p0_addr = raddr[0]; p0_wdata = rwd[0];
      p1_req = rq[1]; p1_we = rwe[1]; p1_addr = raddr[1]; p1_wdata = rwd[1];
      if (m_out) begin
        k = d - m_cmd;
        if (!m_we) begin
          sdram_rdata_valid = (k == m_dly);
          sdram_rdata = (k == m_dly) ? m_rd : $urandom;
          sdram_busy = ($urandom % 4 == 0);
        end else begin
          sdram_busy = (k >= m_s && k < m_s + m_len);
          sdram_rdata_valid = ($urandom % 8 == 0);
          sdram_rdata = $urandom;
        end
      end else begin
        sdram_busy = ($urandom % 6 == 0);
        sdram_rdata_valid = ($urandom % 6 == 0);
        sdram_rdata = $urandom;
      end
      q[0] = rq[0] && !ackp[0];
      q[1] = rq[1] && !ackp[1];
      if (!m_out && !sdram_busy && (q[0] || q[1])) begin
        e_cmd   = 1;
        e_port  = (q[0] && q[1]) ? !m_last : q[1];
        e_we    = rwe[e_port];
        e_addr  = raddr[e_port];
        e_wdata = rwd[e_port];
      end else begin
        e_cmd = 0;
      end
      @(negedge clk);
    end
    clear_inputs();
  endtask

  initial begin
    vec_t vecs[9];
    bit   seen;
    vecs[0] = '{0, 0, 24'h000123, 32'h0,        4,  32'hCAFEF00D, 5,  32'hCAFEF00D, 0};
    vecs[1] = '{1, 1, 24'h3FFFFF, 32'h12345678, 5,  32'h0,        7,  32'h0,        0};
    vecs[2] = '{1, 0, 24'h000456, 32'h0,        0,  32'h0BADF00D, 1,  32'h0BADF00D, 0};
    vecs[3] = '{0, 1, 24'h000001, 32'hA5A5A5A5, 1,  32'h0,        3,  32'h0,        0};
    vecs[4] = '{0, 0, 24'hABCDEF, 32'h0,        14, 32'h13579BDF, 15, 32'h13579BDF, 0};
    vecs[5] = '{1, 1, 24'h000010, 32'h5A5A0001, 13, 32'h0,        15, 32'h0,        0};
    vecs[6] = '{0, 0, 24'h0000FF, 32'h0,        -1, 32'h11111111, 15, 32'hDEADBEEF, 1};
    vecs[7] = '{1, 1, 24'h800000, 32'h77777777, 0,  32'h0,        15, 32'h0,        1};
    vecs[8] = '{1, 0, 24'h000042, 32'h0,        2,  32'h89ABCDEF, 3,  32'h89ABCDEF, 1};

    reset = 1;
    clear_inputs();
    repeat (3) @(negedge clk);
    reset = 0;
    chk("reset_ctrl", {sdram_rd, sdram_wr, p0_ack, p1_ack, owner, active, err_timeout}, 0);
    chk("reset_addr", sdram_addr, 0);
    chk("reset_wdata", sdram_wdata, 0);
    chk("reset_rdata", {p0_rdata, p1_rdata}, 0);
    @(negedge clk);
    chk("idle_quiet", {sdram_rd, sdram_wr, p0_ack, p1_ack, active}, 0);

    run_contention(4);

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    seen = 0;
    for (int j = 0; j < 8; j++) begin
      sdram_rdata_valid = (j % 2 == 0);
      sdram_busy = (j % 3 == 0);
      sdram_rdata = $urandom;
      @(negedge clk);
      if (p0_ack | p1_ack | sdram_rd | sdram_wr) seen = 1;
    end
    chk("stray_strobe_no_ack", seen, 0);
    clear_inputs();

    do_reset();
    run_random(1500);

    p1_we = 1; p1_addr = 24'h000777; p1_wdata = 32'hFEEDFACE; p1_req = 1;
    seen = 0;
    for (int k = 0; k < 6 && !seen; k++) begin
      @(negedge clk);
      if (sdram_wr) seen = 1;
    end
    chk("rst_pre_wr", {seen, owner, active}, 3'b111);
    @(negedge clk);
    sdram_busy = 1;
    #2 reset = 1;
    #1;
    chk("rst_async_ctrl", {sdram_rd, sdram_wr, p0_ack, p1_ack, owner, active, err_timeout}, 0);
    chk("rst_async_data", {sdram_addr, sdram_wdata}, 0);
    chk("rst_async_rdata", {p0_rdata, p1_rdata}, 0);
    clear_inputs();
    repeat (2) @(negedge clk);
    reset = 0;
    no_activity("rst_no_ack", 5);
    run_contention(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sdram_port_arbiter.md
# sdram_port_arbiter

Two-requester arbiter that shares the single SDRAM word interface (rd/wr pulse, 24-bit word address, busy, rdata_valid) between the CPU memory path (port 0) and a second bus master such as a weight-streaming DMA or matmul engine (port 1). It sits between the requesters and the SDRAM controller, in the same 133 MHz domain. It sequences one word transaction at a time and grants round-robin. A timeout watchdog guarantees every request is eventually acknowledged.

## Interface
Parameters:
- TIMEOUT_CYCLES, 1023: maximum cycles spent in a wait state before forced completion; counter is 10 bits wide.
- TIMEOUT_RDATA, 32'hDEADBEEF: read data returned on a timed-out read.

Ports:
- clk  in  1  system clock, same as SDRAM controller
- reset  in  1  asynchronous, active-high
- p0_req / p1_req  in  1  request, level; held until matching ack
- p0_we / p1_we  in  1  1 = write, 0 = read; stable while req
- p0_addr / p1_addr  in  24  word address; stable while req
- p0_wdata / p1_wdata  in  32  write data; stable while req
- p0_ack / p1_ack  out  1  one-cycle completion pulse
- p0_rdata / p1_rdata  out  32  read data, valid when ack is high
- sdram_rd / sdram_wr  out  1  one-cycle command pulses
- sdram_addr  out  24  registered command address
- sdram_wdata  out  32  registered write data
- sdram_rdata  in  32  controller read data
- sdram_busy  in  1  controller busy
- sdram_rdata_valid  in  1  read data strobe
- owner  out  1  port of current or last grant
- active  out  1  high from grant until ack
- err_timeout  out  1  sticky flag, set on any timeout

## Operation
- Reset state: all outputs 0; state IDLE; last_grant = 1, so port 0 wins the first tie.
- Qualified request: qN = pN_req & ~pN_ack. A port is never re-granted in the cycle its ack is high, so requesters may drop req on the ack cycle.
- States: IDLE, WAIT_RD, WAIT_WR.
- IDLE:
  - Grant only when sdram_busy = 0 and q0 | q1.
  - With one requester, grant it. With both, grant the port ≠ last_grant.
  - On grant: latch addr and wdata into sdram_addr/sdram_wdata; pulse sdram_rd or sdram_wr (registered); set owner and last_grant to the granted port; active = 1; clear timer.
  - Next state: WAIT_RD for a read, WAIT_WR for a write.
- WAIT_RD:
  - On sdram_rdata_valid: copy sdram_rdata to the owner's rdata, pulse the owner's ack, active = 0, go to IDLE.
- WAIT_WR:
  - A started flag is set on the first cycle sdram_busy = 1.
  - When started = 1 and sdram_busy = 0: pulse ack (rdata = 0), go to IDLE.
- Timeout:
  - The timer increments every cycle in WAIT_RD/WAIT_WR.
  - When it reaches TIMEOUT_CYCLES without completion: force ack (rdata = TIMEOUT_RDATA for reads, 0 for writes), set err_timeout, go to IDLE.
- The non-owner's ack and rdata stay 0.
- rdata_valid or busy edges seen in IDLE are ignored; stray strobes must not produce an ack.
- Changing req, we, addr or wdata mid-transaction is illegal and is not checked; the latched values are used.

## Timing
- Grant decision in cycle N (IDLE). sdram_rd/sdram_wr, sdram_addr and sdram_wdata are visible at N+1 for exactly one cycle.
- Read: rdata_valid sampled from N+1. If valid is first seen at cycle M, ack and rdata are asserted at M+1, and state is IDLE at M+1.
- Write: ack follows one cycle after the first busy-low cycle that comes after a busy-high cycle.
- Back-to-back: next grant is possible at M+1 (the ack cycle) for the other port. The same port can be granted no earlier than M+2.
- Minimum turnaround per transaction: 3 cycles (grant, controller response, ack).
- Timeout ack fires at cycle N+1+TIMEOUT_CYCLES if no completion event occurs.
- Reset asserted mid-transaction: every output returns to 0 immediately (asynchronous). No ack is emitted for the aborted request.
- Simultaneous completion event and timeout in the same cycle: the completion wins, err_timeout is not set, and real data is returned.

## Test plan
- Single read, port 0, addr 24'h000123. Controller returns 32'hCAFEF00D with rdata_valid 4 cycles after sdram_rd. Required: one sdram_rd pulse with sdram_addr = 24'h000123; p0_ack one cycle after valid with p0_rdata = 32'hCAFEF00D; p1_ack stays 0.
- Single write, port 1, addr 24'h3FFFFF, data 32'h12345678. Busy goes high for 5 cycles. Required: one sdram_wr pulse carrying that address and data; p1_ack exactly one cycle after busy falls.
- Both ports request reads continuously from reset. Required: grant order 0,1,0,1 over four transactions; no sdram_rd issued while busy = 1; every request gets exactly one ack.
- Requester drops req on its ack cycle while the other port idles. Required: no duplicate command issued for the same port.
- Read with rdata_valid never asserted, TIMEOUT_CYCLES = 15. Required: ack at cycle N+16 with rdata = 32'hDEADBEEF; err_timeout = 1 and stays set across later good transactions until reset.
- Reset pulsed two cycles after a write grant. Required: all outputs 0; no ack; after release, a fresh port 0 request is serviced normally and port 0 wins the first tie.
